// File: rtl/a2d_rr_sched.sv
// -----------------------------------------------------------------------------
// a2d_rr_sched
//   Round-robin conversion scheduler for the shared ADC128S A2D behind the SPI
//   master. Each accepted nxt runs one two-transaction conversion on the current
//   channel (lft, rght, steer, batt), captures the 12-bit result into that
//   channel's register, and advances to the next channel.
//
// Ports
//   clk, rst_n       system clock, asynchronous active-low reset
//   nxt              single-cycle request to start the next conversion
//   done, rd_data    SPI master completion pulse and receive word
//   wrt, cmd         SPI transaction start pulse and transmit word
//   lft_ld, rght_ld, steer_pot, batt   latest 12-bit results
//   cnv_cmplt        pulses in the cycle a result register updates
//   busy             conversion in progress
//   wdog_err         sticky: a conversion was aborted waiting for done
// -----------------------------------------------------------------------------
// state | meaning
// IDLE  | waiting for nxt
// XMT1  | address transaction in flight, reply discarded
// GAP   | idle spacing before the read transaction
// XMT2  | read transaction in flight, reply is the result
// -----------------------------------------------------------------------------
module a2d_rr_sched #(
  parameter int unsigned GAP_CYCLES  = 2,
  parameter int unsigned WDOG_CYCLES = 4096,
  parameter logic [2:0]  CH_LFT      = 3'd0,
  parameter logic [2:0]  CH_RGHT     = 3'd4,
  parameter logic [2:0]  CH_STEER    = 3'd5,
  parameter logic [2:0]  CH_BATT     = 3'd6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        nxt,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic        wrt,
  output logic [15:0] cmd,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] steer_pot,
  output logic [11:0] batt,
  output logic        cnv_cmplt,
  output logic        busy,
  output logic        wdog_err
);

  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned WW = $clog2(WDOG_CYCLES);

  typedef enum logic [1:0] {IDLE, XMT1, GAP, XMT2} state_t;

  state_t        state_q, state_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic [WW-1:0] wdog_cnt_q, wdog_cnt_d;
  logic          wrt_q, wrt_d;
  logic [15:0]   cmd_q, cmd_d;
  logic [11:0]   lft_q, lft_d;
  logic [11:0]   rght_q, rght_d;
  logic [11:0]   steer_q, steer_d;
  logic [11:0]   batt_q, batt_d;
  logic          cnv_cmplt_q, cnv_cmplt_d;
  logic          wdog_err_q, wdog_err_d;
  logic [2:0]    ch_sel;

  // Only the low 12 bits of the SPI reply carry the conversion.
  logic unused_rd_hi;
  assign unused_rd_hi = ^rd_data[15:12];

  always_comb begin
    case (ptr_q)
      2'd0:    ch_sel = CH_LFT;
      2'd1:    ch_sel = CH_RGHT;
      2'd2:    ch_sel = CH_STEER;
      default: ch_sel = CH_BATT;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gap_cnt_d   = gap_cnt_q;
    wdog_cnt_d  = wdog_cnt_q;
    wrt_d       = 1'b0;
    cmd_d       = cmd_q;
    lft_d       = lft_q;
    rght_d      = rght_q;
    steer_d     = steer_q;
    batt_d      = batt_q;
    cnv_cmplt_d = 1'b0;
    wdog_err_d  = wdog_err_q;

    case (state_q)
      IDLE: begin
        // A done arriving here is stale and deliberately ignored.
        if (nxt) begin
          state_d    = XMT1;
          wrt_d      = 1'b1;
          cmd_d      = {2'b00, ch_sel, 11'h000};
          wdog_cnt_d = WW'(WDOG_CYCLES - 1);
        end
      end
      XMT1: begin
        if (done) begin
          state_d   = GAP;
          gap_cnt_d = GW'(GAP_CYCLES - 1);
        end else if (wdog_cnt_q == '0) begin
          state_d    = IDLE;
          wdog_err_d = 1'b1;
        end else begin
          wdog_cnt_d = wdog_cnt_q - WW'(1);
        end
      end
      GAP: begin
        if (gap_cnt_q == '0) begin
          state_d    = XMT2;
          wrt_d      = 1'b1;
          wdog_cnt_d = WW'(WDOG_CYCLES - 1);
        end else begin
          gap_cnt_d = gap_cnt_q - GW'(1);
        end
      end
      XMT2: begin
        if (done) begin
          case (ptr_q)
            2'd0:    lft_d   = rd_data[11:0];
            2'd1:    rght_d  = rd_data[11:0];
            2'd2:    steer_d = rd_data[11:0];
            default: batt_d  = rd_data[11:0];
          endcase
          cnv_cmplt_d = 1'b1;
          ptr_d       = ptr_q + 2'd1;
          state_d     = IDLE;
        end else if (wdog_cnt_q == '0) begin
          // Abort leaves pointer and results untouched so the channel is retried.
          state_d    = IDLE;
          wdog_err_d = 1'b1;
        end else begin
          wdog_cnt_d = wdog_cnt_q - WW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= 2'd0;
      gap_cnt_q   <= '0;
      wdog_cnt_q  <= '0;
      wrt_q       <= 1'b0;
      cmd_q       <= 16'h0000;
      lft_q       <= 12'h000;
      rght_q      <= 12'h000;
      steer_q     <= 12'h000;
      batt_q      <= 12'h000;
      cnv_cmplt_q <= 1'b0;
      wdog_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gap_cnt_q   <= gap_cnt_d;
      wdog_cnt_q  <= wdog_cnt_d;
      wrt_q       <= wrt_d;
      cmd_q       <= cmd_d;
      lft_q       <= lft_d;
      rght_q      <= rght_d;
      steer_q     <= steer_d;
      batt_q      <= batt_d;
      cnv_cmplt_q <= cnv_cmplt_d;
      wdog_err_q  <= wdog_err_d;
    end
  end

  assign wrt       = wrt_q;
  assign cmd       = cmd_q;
  assign lft_ld    = lft_q;
  assign rght_ld   = rght_q;
  assign steer_pot = steer_q;
  assign batt      = batt_q;
  assign cnv_cmplt = cnv_cmplt_q;
  assign busy      = (state_q != IDLE);
  assign wdog_err  = wdog_err_q;

endmodule

// File: tb/tb_a2d_rr_sched.sv
// -----------------------------------------------------------------------------
// tb_a2d_rr_sched
//   Drives a2d_rr_sched with a behavioural SPI/ADC responder and compares its
//   results against a channel-list model (four result slots, round-robin index).
// -----------------------------------------------------------------------------
module tb_a2d_rr_sched;

  localparam int GAP  = 2;
  localparam int WDOG = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        nxt = 1'b0;
  logic        done_resp = 1'b0;
  logic        done_stray = 1'b0;
  logic [15:0] rd_resp = 16'h0;
  logic [15:0] rd_stray = 16'h0;
  logic        done;
  logic [15:0] rd_data;
  logic        wrt;
  logic [15:0] cmd;
  logic [11:0] lft_ld, rght_ld, steer_pot, batt;
  logic        cnv_cmplt, busy, wdog_err;

  assign done    = done_resp | done_stray;
  assign rd_data = done_stray ? rd_stray : rd_resp;

  a2d_rr_sched #(.GAP_CYCLES(GAP), .WDOG_CYCLES(WDOG)) dut (
    .clk(clk), .rst_n(rst_n), .nxt(nxt), .done(done), .rd_data(rd_data),
    .wrt(wrt), .cmd(cmd), .lft_ld(lft_ld), .rght_ld(rght_ld),
    .steer_pot(steer_pot), .batt(batt), .cnv_cmplt(cnv_cmplt),
    .busy(busy), .wdog_err(wdog_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // ---------------- ADC / SPI behavioural model ----------------
  logic [11:0] adc_val [8];
  logic [15:0] wrt_cmds [$];
  int          conv_base = 0;
  int          resp_lat = 1;
  bit          drop_done = 1'b0;
  int          last_wrt_cyc = 0;

  initial begin : spi_model
    logic [15:0] c;
    int          n;
    forever begin
      @(negedge clk);
      if (wrt === 1'b1) begin
        c = cmd;
        wrt_cmds.push_back(c);
        last_wrt_cyc = cyc;
        n = wrt_cmds.size() - conv_base;
        if (!drop_done) begin
          repeat (resp_lat) @(posedge clk);
          #1;
          done_resp = 1'b1;
          // First transaction returns junk; the second returns the sample.
          rd_resp = (n % 2 == 1) ? 16'($urandom) : {4'($urandom), adc_val[c[13:11]]};
          @(posedge clk);
          #1;
          done_resp = 1'b0;
          rd_resp   = 16'h0;
        end
      end
    end
  end

  // Pulse-width monitor and cnv_cmplt counter.
  int cmplt_cnt = 0;
  int last_cmplt = 0;
  initial begin : pulse_mon
    logic prev_wrt, prev_cc;
    prev_wrt = 1'b0;
    prev_cc  = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_wrt) chk("wrt_width", 32'(wrt), 32'd0);
      if (prev_cc)  chk("cmplt_width", 32'(cnv_cmplt), 32'd0);
      prev_wrt = wrt;
      prev_cc  = cnv_cmplt;
      if (cnv_cmplt === 1'b1) begin
        cmplt_cnt++;
        last_cmplt = cyc;
      end
    end
  end

  // ---------------- reference model ----------------
  logic [2:0]  chans [4] = '{3'd0, 3'd4, 3'd5, 3'd6};
  logic [11:0] m_res [4];
  int          m_ptr = 0;

  function automatic logic [15:0] cmd_of(input logic [2:0] ch);
    return {2'b00, ch, 11'h000};
  endfunction

  task automatic model_conv();
    m_res[m_ptr] = adc_val[chans[m_ptr]];
    m_ptr = (m_ptr + 1) % 4;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_res[i] = 12'h000;
    m_ptr = 0;
  endtask

  task automatic chk_regs(input string tag, input logic [11:0] l, input logic [11:0] r,
                          input logic [11:0] s, input logic [11:0] b);
    chk({tag, ".lft"},   32'(lft_ld),    32'(l));
    chk({tag, ".rght"},  32'(rght_ld),   32'(r));
    chk({tag, ".steer"}, 32'(steer_pot), 32'(s));
    chk({tag, ".batt"},  32'(batt),      32'(b));
  endtask

  task automatic chk_model(input string tag);
    chk_regs(tag, m_res[0], m_res[1], m_res[2], m_res[3]);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".wrt"},  32'(wrt), 32'd0);
    chk({tag, ".cmd"},  32'(cmd), 32'd0);
    chk_regs(tag, 12'h0, 12'h0, 12'h0, 12'h0);
    chk({tag, ".cmplt"}, 32'(cnv_cmplt), 32'd0);
    chk({tag, ".busy"},  32'(busy), 32'd0);
    chk({tag, ".wdog"},  32'(wdog_err), 32'd0);
  endtask

  // One conversion request. stray: 0 none, 1 done one cycle before nxt,
  // 2 done in the same cycle as nxt. extra: nxt pulses issued while busy.
  task automatic run_conv(input int lat, input int hold, input int extra, input int stray,
                          output int latency, output bit ok, output int ncmp,
                          output int nwrt, output logic [15:0] cmd_a,
                          output logic [15:0] cmd_b);
    int c0, start;
    resp_lat  = lat;
    conv_base = wrt_cmds.size();
    c0        = cmplt_cnt;
    @(posedge clk); #1;
    if (stray == 1) begin
      done_stray = 1'b1;
      rd_stray   = 16'($urandom);
      @(posedge clk); #1;
      done_stray = 1'b0;
    end
    nxt   = 1'b1;
    start = cyc;
    if (stray == 2) begin
      done_stray = 1'b1;
      rd_stray   = 16'($urandom);
    end
    for (int i = 1; i < hold; i++) begin
      @(posedge clk); #1;
      done_stray = 1'b0;
    end
    @(posedge clk); #1;
    nxt        = 1'b0;
    done_stray = 1'b0;
    for (int e = 0; e < extra; e++) begin
      @(posedge clk); #1 nxt = 1'b1;
      @(posedge clk); #1 nxt = 1'b0;
    end
    for (int i = 0; i < 200 && cmplt_cnt == c0; i++) @(posedge clk);
    ok      = (cmplt_cnt != c0);
    latency = last_cmplt - start;
    repeat (4) @(posedge clk);
    #1;
    ncmp  = cmplt_cnt - c0;
    nwrt  = wrt_cmds.size() - conv_base;
    cmd_a = (nwrt >= 1) ? wrt_cmds[conv_base]     : 16'hFFFF;
    cmd_b = (nwrt >= 2) ? wrt_cmds[conv_base + 1] : 16'hFFFF;
  endtask

  typedef struct {
    int          lat;
    logic [11:0] lft_in;
    logic [2:0]  ch;
    logic [11:0] e_l, e_r, e_s, e_b;
    int          e_lat;
  } vec_t;

  initial begin : main
    vec_t        tbl [5];
    int          lat, ncmp, nwrt, c0, wd_cyc, delta, hold, stray;
    bit          ok, seen;
    logic [15:0] ca, cb;

    tbl[0] = '{1, 12'h121, 3'd0, 12'h121, 12'h000, 12'h000, 12'h000, 7};
    tbl[1] = '{2, 12'h121, 3'd4, 12'h121, 12'h139, 12'h000, 12'h000, 9};
    tbl[2] = '{3, 12'h121, 3'd5, 12'h121, 12'h139, 12'hE00, 12'h000, 11};
    tbl[3] = '{1, 12'h121, 3'd6, 12'h121, 12'h139, 12'hE00, 12'hFFF, 7};
    tbl[4] = '{1, 12'h240, 3'd0, 12'h240, 12'h139, 12'hE00, 12'hFFF, 7};

    for (int i = 0; i < 8; i++) adc_val[i] = 12'h000;
    adc_val[0] = 12'h121;
    adc_val[4] = 12'h139;
    adc_val[5] = 12'hE00;
    adc_val[6] = 12'hFFF;
    model_reset();

    // Reset state
    #12;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Table: full rotation plus wrap with changed left load
    for (int i = 0; i < 5; i++) begin
      adc_val[0] = tbl[i].lft_in;
      run_conv(tbl[i].lat, 1, 0, 0, lat, ok, ncmp, nwrt, ca, cb);
      model_conv();
      chk($sformatf("tbl%0d.done", i), 32'(ok), 32'd1);
      chk($sformatf("tbl%0d.latency", i), 32'(lat), 32'(tbl[i].e_lat));
      chk($sformatf("tbl%0d.nwrt", i), 32'(nwrt), 32'd2);
      chk($sformatf("tbl%0d.ncmplt", i), 32'(ncmp), 32'd1);
      chk($sformatf("tbl%0d.cmd1", i), 32'(ca), 32'(cmd_of(tbl[i].ch)));
      chk($sformatf("tbl%0d.cmd2", i), 32'(cb), 32'(cmd_of(tbl[i].ch)));
      chk($sformatf("tbl%0d.busy", i), 32'(busy), 32'd0);
      chk_regs($sformatf("tbl%0d", i), tbl[i].e_l, tbl[i].e_r, tbl[i].e_s, tbl[i].e_b);
    end

    // nxt held 3 cycles plus extra requests while busy
    adc_val[4] = 12'h0AB;
    run_conv(1, 3, 2, 0, lat, ok, ncmp, nwrt, ca, cb);
    model_conv();
    chk("hold.ncmplt", 32'(ncmp), 32'd1);
    chk("hold.nwrt", 32'(nwrt), 32'd2);
    chk("hold.cmd1", 32'(ca), 32'(cmd_of(3'd4)));
    chk_model("hold");

    // Watchdog: done never returns
    drop_done = 1'b1;
    conv_base = wrt_cmds.size();
    c0 = cmplt_cnt;
    @(posedge clk); #1 nxt = 1'b1;
    @(posedge clk); #1 nxt = 1'b0;
    seen = 1'b0;
    wd_cyc = 0;
    for (int i = 0; i < WDOG + 50 && !seen; i++) begin
      @(posedge clk); #1;
      if (wdog_err === 1'b1) begin
        seen   = 1'b1;
        wd_cyc = cyc;
      end
    end
    delta = wd_cyc - last_wrt_cyc;
    chk("wdog.seen", 32'(seen), 32'd1);
    chk("wdog.delay_in_window", 32'(delta >= WDOG - 1 && delta <= WDOG + 1), 32'd1);
    drop_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("wdog.busy", 32'(busy), 32'd0);
    chk("wdog.nwrt", 32'(wrt_cmds.size() - conv_base), 32'd1);
    chk("wdog.ncmplt", 32'(cmplt_cnt - c0), 32'd0);
    chk_model("wdog");
    run_conv(1, 1, 0, 0, lat, ok, ncmp, nwrt, ca, cb);
    model_conv();
    chk("retry.cmd1", 32'(ca), 32'(cmd_of(3'd5)));
    chk("retry.ncmplt", 32'(ncmp), 32'd1);
    chk("retry.wdog_sticky", 32'(wdog_err), 32'd1);
    chk_model("retry");

    // Reset asserted during GAP
    resp_lat  = 1;
    conv_base = wrt_cmds.size();
    @(posedge clk); #1 nxt = 1'b1;
    @(posedge clk); #1 nxt = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("midrst.nwrt", 32'(wrt_cmds.size() - conv_base), 32'd1);
    chk_zero("midrst_after");
    run_conv(1, 1, 0, 0, lat, ok, ncmp, nwrt, ca, cb);
    model_conv();
    chk("midrst.cmd1", 32'(ca), 32'(cmd_of(3'd0)));
    chk_model("midrst_conv");

    // Randomized conversions against the model
    for (int it = 0; it < 40; it++) begin
      for (int k = 0; k < 4; k++) adc_val[chans[k]] = 12'($urandom);
      lat   = $urandom_range(1, 4);
      hold  = $urandom_range(1, 3);
      stray = $urandom_range(0, 2);
      c0    = m_ptr;
      run_conv(lat, hold, 0, stray, delta, ok, ncmp, nwrt, ca, cb);
      model_conv();
      chk($sformatf("rnd%0d.done", it), 32'(ok), 32'd1);
      chk($sformatf("rnd%0d.latency", it), 32'(delta), 32'(3 + GAP + 2 * lat));
      chk($sformatf("rnd%0d.ncmplt", it), 32'(ncmp), 32'd1);
      chk($sformatf("rnd%0d.nwrt", it), 32'(nwrt), 32'd2);
      chk($sformatf("rnd%0d.cmd1", it), 32'(ca), 32'(cmd_of(chans[c0])));
      chk($sformatf("rnd%0d.cmd2", it), 32'(cb), 32'(cmd_of(chans[c0])));
      chk_model($sformatf("rnd%0d", it));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
